pr_bridge: RTL and testbench

//  Peripheral-side consumer of the MEM stage bus (PrAddr/PrWData/PrMask/PrWrite/PrRData, addr >= 0x7f00).

---
 rtl/pr_bridge_pkg.sv | 45 ++++
 rtl/pr_timer.sv | 92 +++++++++
 rtl/pr_bridge.sv | 57 +++++
 tb/tb_pr_bridge.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/pr_bridge_pkg.sv
// Shared definitions for the peripheral bridge: register map, CTRL layout,
// timer FSM encoding and the bus request/readback structs.
package pr_bridge_pkg;

    localparam int NUM_TC = 2;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;

    localparam int CTRL_W        = 4;
    localparam int CTRL_EN       = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_IM       = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_CNT  = 2'd2;
    localparam logic [1:0] ST_INT  = 2'd3;

    typedef struct packed {
        logic        ctrl_we;
        logic        preset_we;
        logic [31:0] wdata;
    } tc_wr_t;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [31:0]       preset;
        logic [31:0]       count;
    } tc_regs_t;

    function automatic logic [31:0] reg_rdata(input tc_regs_t r, input logic [1:0] sel);
        case (sel)
            REG_CTRL:   return {{(32-CTRL_W){1'b0}}, r.ctrl};
            REG_PRESET: return r.preset;
            REG_COUNT:  return r.count;
            default:    return 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/pr_timer.sv
// One count-down timer: CTRL/PRESET/COUNT registers, IDLE/LOAD/CNT/INT
// sequencer and the masked interrupt output.
module pr_timer
    import pr_bridge_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  tc_wr_t   wr,
    output tc_regs_t regs,
    output logic     irq
);

    logic [1:0]        state_q, state_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [31:0]       preset_q, preset_d;
    logic [31:0]       count_q, count_d;
    logic              flag_q, flag_d;
    logic              reload;
    logic              en_eff;

    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        count_d  = count_q;
        flag_d   = flag_q;
        reload   = (ctrl_q[CTRL_MODE_LSB +: 2] == MODE_RELOAD);
        // A disabling CTRL write freezes COUNT on the very edge that takes it.
        en_eff   = wr.ctrl_we ? wr.wdata[CTRL_EN] : ctrl_q[CTRL_EN];

        if (wr.ctrl_we && !reload)
            flag_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ctrl_q[CTRL_EN])
                    state_d = ST_LOAD;
            end
            ST_LOAD: begin
                count_d = preset_q;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!en_eff) begin
                    state_d = ST_IDLE;
                end else if (count_q == 32'h0) begin
                    state_d = ST_INT;
                    flag_d  = 1'b1;
                end else begin
                    count_d = count_q - 32'd1;
                end
            end
            default: begin
                if (reload) begin
                    flag_d  = 1'b0;
                    state_d = ST_LOAD;
                end else begin
                    ctrl_d[CTRL_EN] = 1'b0;
                    state_d         = ST_IDLE;
                end
            end
        endcase

        // Bus write lands after the FSM so it overrides the one-shot EN clear.
        if (wr.ctrl_we)
            ctrl_d = wr.wdata[CTRL_W-1:0];
        if (wr.preset_we)
            preset_d = wr.wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ctrl_q   <= '0;
            preset_q <= '0;
            count_q  <= '0;
            flag_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            flag_q   <= flag_d;
        end
    end

    assign regs.ctrl   = ctrl_q;
    assign regs.preset = preset_q;
    assign regs.count  = count_q;
    assign irq         = flag_q & ctrl_q[CTRL_IM];

endmodule

// File: rtl/pr_bridge.sv
// MEM-stage peripheral bridge: decodes the Pr* bus onto two timers and
// returns their registers combinationally; HWInt carries the timer irqs.
module pr_bridge
    import pr_bridge_pkg::*;
#(
    parameter logic [31:0] TC0_BASE = 32'h0000_7f00,
    parameter logic [31:0] TC1_BASE = 32'h0000_7f10
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] PrAddr,
    input  logic [31:0] PrWData,
    input  logic [3:0]  PrMask,
    input  logic        PrWrite,
    output logic [31:0] PrRData,
    output logic [1:0]  HWInt
);

    localparam logic [NUM_TC-1:0][31:0] TC_BASE = {TC1_BASE, TC0_BASE};

    logic [NUM_TC-1:0]           hit;
    tc_wr_t   [NUM_TC-1:0]       tc_wr;
    tc_regs_t [NUM_TC-1:0]       tc_regs;
    logic [1:0]                  reg_sel;
    logic                        wr_ok;
    logic [1:0]                  unused_addr_bits;

    assign unused_addr_bits = PrAddr[1:0];

    always_comb begin
        reg_sel = PrAddr[3:2];
        // Partial-word writes are dropped entirely.
        wr_ok   = PrWrite && (PrMask == 4'b1111);
        PrRData = 32'h0;
        for (int i = 0; i < NUM_TC; i++) begin
            hit[i]             = (PrAddr[31:4] == TC_BASE[i][31:4]);
            tc_wr[i].ctrl_we   = wr_ok && hit[i] && (reg_sel == REG_CTRL);
            tc_wr[i].preset_we = wr_ok && hit[i] && (reg_sel == REG_PRESET);
            tc_wr[i].wdata     = PrWData;
            if (hit[i])
                PrRData = PrRData | reg_rdata(tc_regs[i], reg_sel);
        end
    end

    generate
        for (genvar g = 0; g < NUM_TC; g++) begin : g_tc
            pr_timer u_tmr (
                .clk  (Clk),
                .rst  (Rst),
                .wr   (tc_wr[g]),
                .regs (tc_regs[g]),
                .irq  (HWInt[g])
            );
        end
    endgenerate

endmodule

// File: tb/tb_pr_bridge.sv
// Directed bench for pr_bridge: expected values queued when each step is
// driven, popped and asserted when the DUT output is sampled.
module tb_pr_bridge;

    logic        Clk;
    logic        Rst;
    logic [31:0] PrAddr;
    logic [31:0] PrWData;
    logic [3:0]  PrMask;
    logic        PrWrite;
    logic [31:0] PrRData;
    logic [1:0]  HWInt;

    logic [31:0] exp_q[$];
    int          n_chk  = 0;
    int          n_pass = 0;

    pr_bridge dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .PrAddr  (PrAddr),
        .PrWData (PrWData),
        .PrMask  (PrMask),
        .PrWrite (PrWrite),
        .PrRData (PrRData),
        .HWInt   (HWInt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        exp = exp_q.pop_front();
        n_chk = n_chk + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        PrAddr  = addr;
        PrWrite = 1'b0;
        exp_q.push_back(exp);
        #1;
        check(tag, PrRData);
    endtask

    task automatic hw_chk(input string tag, input logic [1:0] exp);
        exp_q.push_back({30'h0, exp});
        #1;
        check(tag, {30'h0, HWInt});
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
        PrAddr  = addr;
        PrWData = data;
        PrMask  = mask;
        PrWrite = 1'b1;
        cyc();
        PrWrite = 1'b0;
    endtask

    initial begin
        Rst = 1'b1; PrAddr = '0; PrWData = '0; PrMask = 4'hF; PrWrite = 1'b0;
        cyc(); cyc();
        Rst = 1'b0;

        // 1: reset state
        rd_chk("rst_ctrl0",   32'h7f00, 32'h0);
        rd_chk("rst_preset0", 32'h7f04, 32'h0);
        rd_chk("rst_count0",  32'h7f08, 32'h0);
        rd_chk("rst_unmap1",  32'h7f1c, 32'h0);
        hw_chk("rst_hwint",   2'b00);

        // 2: one-shot TC0 from 3 with IM
        wr(32'h7f04, 32'd3, 4'hF);
        wr(32'h7f00, 32'h9, 4'hF);
        cyc();
        cyc(); rd_chk("os_cnt3", 32'h7f08, 32'd3); hw_chk("os_irq_lo3", 2'b00);
        cyc(); rd_chk("os_cnt2", 32'h7f08, 32'd2);
        cyc(); rd_chk("os_cnt1", 32'h7f08, 32'd1);
        cyc(); rd_chk("os_cnt0", 32'h7f08, 32'd0); hw_chk("os_irq_lo0", 2'b00);
        cyc(); hw_chk("os_irq_rise", 2'b01);
        cyc(); rd_chk("os_ctrl_en_clr", 32'h7f00, 32'h8); hw_chk("os_irq_hold1", 2'b01);
        cyc(); hw_chk("os_irq_hold2", 2'b01); rd_chk("os_cnt_stay0", 32'h7f08, 32'd0);
        wr(32'h7f00, 32'h0, 4'hF);
        hw_chk("os_irq_clr", 2'b00);

        // 3: auto-reload TC1, period PRESET+3 = 5
        wr(32'h7f14, 32'd2, 4'hF);
        wr(32'h7f10, 32'hB, 4'hF);
        for (int k = 1; k <= 16; k++) begin
            cyc();
            hw_chk($sformatf("ar_irq_k%0d", k), (k % 5 == 0) ? 2'b10 : 2'b00);
        end
        wr(32'h7f10, 32'h0, 4'hF);
        cyc(); cyc(); cyc(); cyc();
        hw_chk("ar_off", 2'b00);

        // 4: disable mid-count, then re-enable reloads PRESET
        wr(32'h7f04, 32'd10, 4'hF);
        wr(32'h7f00, 32'h1, 4'hF);
        for (int k = 0; k < 6; k++) cyc();
        rd_chk("mid_cnt6", 32'h7f08, 32'd6);
        wr(32'h7f00, 32'h0, 4'hF);
        rd_chk("mid_hold_a", 32'h7f08, 32'd6);
        cyc(); cyc(); cyc();
        rd_chk("mid_hold_b", 32'h7f08, 32'd6);
        hw_chk("mid_no_irq", 2'b00);
        wr(32'h7f00, 32'h9, 4'hF);
        cyc();
        cyc(); rd_chk("mid_reload10", 32'h7f08, 32'd10);
        wr(32'h7f00, 32'h0, 4'hF);
        cyc(); cyc();
        rd_chk("mid_stop10", 32'h7f08, 32'd10);

        // 5: ignored writes
        wr(32'h7f08, 32'h55, 4'hF);
        rd_chk("ign_count_ro", 32'h7f08, 32'd10);
        wr(32'h7f04, 32'h77, 4'b0011);
        rd_chk("ign_preset_mask", 32'h7f04, 32'd10);
        wr(32'h7f00, 32'h9, 4'b0011);
        cyc(); cyc(); cyc();
        rd_chk("ign_ctrl_mask", 32'h7f00, 32'h0);
        rd_chk("ign_no_start", 32'h7f08, 32'd10);
        wr(32'h7f0c, 32'h1234, 4'hF);
        rd_chk("ign_unmap_rd", 32'h7f0c, 32'h0);
        rd_chk("ign_unmap_preset", 32'h7f04, 32'd10);
        rd_chk("ign_out_of_range", 32'h7f20, 32'h0);
        wr(32'h7f00, 32'hFFFF_FFF8, 4'hF);
        rd_chk("ctrl_hi_bits", 32'h7f00, 32'h8);
        hw_chk("ctrl_im_no_flag", 2'b00);
        wr(32'h7f00, 32'h0, 4'hF);

        // 6: reset mid-count on auto-reload TC1
        wr(32'h7f14, 32'd20, 4'hF);
        wr(32'h7f10, 32'h3, 4'hF);
        for (int k = 0; k < 18; k++) cyc();
        rd_chk("rst_mid_cnt4", 32'h7f18, 32'd4);
        Rst = 1'b1;
        cyc();
        Rst = 1'b0;
        rd_chk("rst_mid_ctrl1",   32'h7f10, 32'h0);
        rd_chk("rst_mid_count1",  32'h7f18, 32'h0);
        rd_chk("rst_mid_preset1", 32'h7f14, 32'h0);
        rd_chk("rst_mid_preset0", 32'h7f04, 32'h0);
        hw_chk("rst_mid_hwint", 2'b00);
        cyc(); cyc(); cyc();
        rd_chk("rst_idle_count1", 32'h7f18, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
